// File: rtl/counter_uart_reporter_pkg.sv
// Shared definitions for the counter UART reporter.
//   - ASCII constants used to build the report line
//   - hex_digit(): nibble to uppercase ASCII hex character
//   - ctrl_state_t: controller FSM states
//   - calc_div(): clock cycles per serial bit
package counter_uart_reporter_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_CHAR,
        SEND,
        FINISH
    } ctrl_state_t;

    // Integer truncation; the caller must keep the result >= 2.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic logic [7:0] hex_digit(input logic [3:0] n);
        if (n < 4'd10)
            return ASCII_0 + {4'h0, n};
        else
            return ASCII_A + {4'h0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/counter_uart_reporter_uart_tx_byte.sv
// 8N1 byte serializer.
//   CLK     : system clock, rising edge
//   RSTN    : synchronous active-low reset
//   load    : start a frame with byte_in (taken only while ready=1)
//   byte_in : byte to send, LSB first
//   ready   : idle, or in the final cycle of the stop bit (back-to-back load)
//   done    : high in the final cycle of the stop bit
//   TX      : serial line, idle high
// The byte port is named byte_in because "byte" is a reserved word.
module uart_tx_byte #(
    parameter int DIV = 104
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       ready,
    output logic       done,
    output logic       TX
);

    localparam int             CW       = $clog2(DIV);
    localparam logic [CW-1:0]  DIV_LAST = CW'(DIV - 1);

    logic          active;
    logic [CW-1:0] div_cnt;
    logic [3:0]    bit_idx;    // 0 = start, 1..8 = data, 9 = stop
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (div_cnt == DIV_LAST);
    // done/ready look one edge ahead so a new frame can start on the very
    // edge that ends the current stop bit, with no idle cycle in between.
    assign done    = active && bit_end && (bit_idx == 4'd9);
    assign ready   = !active || done;

    // NOTE: all state here is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others, like real flops.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            TX      <= 1'b1;
        end else if (load && ready) begin
            active  <= 1'b1;
            div_cnt <= '0;
            bit_idx <= '0;
            shreg   <= byte_in;
            TX      <= 1'b0;
        end else if (active) begin
            if (bit_end) begin
                div_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    active  <= 1'b0;
                    bit_idx <= '0;
                    TX      <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    if (bit_idx == 4'd8) begin
                        TX <= 1'b1;
                    end else begin
                        TX    <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                    end
                end
            end else begin
                div_cnt <= div_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/counter_uart_reporter.sv
// Reports a captured 8-bit counter value over UART as "HH\r\n" (8N1).
//   CLK   : system clock, rising edge
//   RSTN  : synchronous active-low reset
//   DATA  : value to report, latched when a start is accepted
//   START : request, accepted whenever BUSY=0
//   BUSY  : high for the 40*DIV cycles of a report
//   DONE  : one-cycle pulse after the final stop bit
//   TX    : UART serial line, idle high
module counter_uart_reporter
    import counter_uart_reporter_pkg::*;
#(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic [7:0] DATA,
    input  logic       START,
    output logic       BUSY,
    output logic       DONE,
    output logic       TX
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);

    ctrl_state_t state;
    logic [7:0]  hold;
    logic [1:0]  idx;       // character currently on the line
    logic        accept;
    logic        ser_load;
    logic        ser_ready;
    logic        ser_done;
    logic [7:0]  ser_byte;

    // FINISH is the DONE cycle with BUSY=0, so a start is accepted there too.
    assign accept   = !BUSY && START;
    // In SEND the serializer is always active, so ready rises only in the
    // last stop-bit cycle; the next character is loaded on that same edge.
    assign ser_load = accept || ((state == SEND) && ser_ready && (idx != 2'd3));

    // NOTE: ser_byte gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        ser_byte = hex_digit(DATA[7:4]);    // first character comes straight from DATA
        if (!accept) begin
            case (idx)
                2'd0:    ser_byte = hex_digit(hold[3:0]);
                2'd1:    ser_byte = ASCII_CR;
                default: ser_byte = ASCII_LF;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state <= IDLE;
            hold  <= '0;
            idx   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE, FINISH: begin
                    if (accept) begin
                        hold  <= DATA;
                        idx   <= '0;
                        BUSY  <= 1'b1;
                        state <= LOAD_CHAR;
                    end else begin
                        state <= IDLE;
                    end
                end
                // The serializer already took the character on the entering edge.
                LOAD_CHAR: state <= SEND;
                SEND: begin
                    if (ser_done) begin
                        if (idx == 2'd3) begin
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= LOAD_CHAR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .DIV(DIV)
    ) u_tx (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .load    (ser_load),
        .byte_in (ser_byte),
        .ready   (ser_ready),
        .done    (ser_done),
        .TX      (TX)
    );

endmodule

// File: tb/tb_counter_uart_reporter.sv
// Directed bench for counter_uart_reporter: a DIV=4 instance for most
// scenarios and a default-parameter instance (DIV=104) for bit timing.
module tb_counter_uart_reporter;

    localparam int DIV_A = 4;      // 1 MHz / 250 kbaud
    localparam int DIV_B = 104;    // 12 MHz / 115200 baud, truncated

    logic       clk;
    logic       rstn;
    logic [7:0] data, data_b;
    logic       start, start_b;
    logic       busy, done, tx;
    logic       busy_b, done_b, tx_b;

    int n_checks = 0;
    int n_pass   = 0;

    counter_uart_reporter #(
        .CLK_HZ(1000000),
        .BAUD  (250000)
    ) dut (
        .CLK  (clk),
        .RSTN (rstn),
        .DATA (data),
        .START(start),
        .BUSY (busy),
        .DONE (done),
        .TX   (tx)
    );

    counter_uart_reporter dut_def (
        .CLK  (clk),
        .RSTN (rstn),
        .DATA (data_b),
        .START(start_b),
        .BUSY (busy_b),
        .DONE (done_b),
        .TX   (tx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n <= 4'd9)
            return 8'h30 + {4'h0, n};
        return 8'h37 + {4'h0, n};    // 'A' = 0x37 + 10
    endfunction

    // Called at a negedge right after START/DATA were driven. Walks every
    // cycle of the report comparing TX to the ideal 8N1 waveform, decodes
    // each character at mid-bit, then checks the DONE cycle.
    // mode 0: drop START after accept; 1: keep START high;
    // mode 2: drop START, then assert START with DATA=FF mid-report.
    task automatic capture_report(input bit use_b, input int div, input logic [7:0] val,
                                  input int mode, input string tag);
        logic [7:0] exp_ch [4];
        logic [7:0] rx;
        logic       exp_bit, s_tx, s_busy, s_done;
        int         bad, busy_cnt, done_cnt, cyc;
        exp_ch[0] = hex_ascii(val[7:4]);
        exp_ch[1] = hex_ascii(val[3:0]);
        exp_ch[2] = 8'h0D;
        exp_ch[3] = 8'h0A;
        bad = 0; busy_cnt = 0; done_cnt = 0; cyc = 0; rx = '0;
        for (int c = 0; c < 4; c++) begin
            for (int b = 0; b < 10; b++) begin
                for (int k = 0; k < div; k++) begin
                    @(negedge clk);
                    cyc++;
                    if (cyc == 1 && mode != 1) begin
                        start   = 1'b0;
                        start_b = 1'b0;
                    end
                    if (mode == 2 && cyc == 30) begin
                        data  = 8'hFF;
                        start = 1'b1;
                    end
                    if (mode == 2 && cyc == 40) start = 1'b0;
                    s_tx   = use_b ? tx_b   : tx;
                    s_busy = use_b ? busy_b : busy;
                    s_done = use_b ? done_b : done;
                    exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_ch[c][b-1];
                    if (s_tx !== exp_bit) bad++;
                    if (s_busy === 1'b1) busy_cnt++;
                    if (s_done !== 1'b0) done_cnt++;
                    if (k == div / 2 && b >= 1 && b <= 8) rx[b-1] = s_tx;
                end
            end
            check($sformatf("%s char%0d", tag, c), rx, exp_ch[c]);
        end
        check({tag, " tx bit errors"}, bad, 0);
        check({tag, " busy cycles"}, busy_cnt, 40 * div);
        check({tag, " early done"}, done_cnt, 0);
        @(negedge clk);
        check({tag, " done pulse"}, use_b ? done_b : done, 1'b1);
        check({tag, " busy at done"}, use_b ? busy_b : busy, 1'b0);
        check({tag, " tx at done"}, use_b ? tx_b : tx, 1'b1);
    endtask

    initial begin
        int cnt;
        rstn = 1'b0; data = '0; data_b = '0; start = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        check("reset tx", tx, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset busy def", busy_b, 1'b0);
        check("reset tx def", tx_b, 1'b1);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // 1: A5 -> "A5\r\n", then DONE drops after one cycle
        data = 8'hA5; start = 1'b1;
        capture_report(1'b0, DIV_A, 8'hA5, 0, "A5");
        @(negedge clk);
        check("A5 done one cycle", done, 1'b0);
        check("A5 idle tx", tx, 1'b1);

        // 2: digit/letter boundaries
        data = 8'h09; start = 1'b1;
        capture_report(1'b0, DIV_A, 8'h09, 0, "09");
        repeat (2) @(negedge clk);
        data = 8'hF0; start = 1'b1;
        capture_report(1'b0, DIV_A, 8'hF0, 0, "F0");
        repeat (2) @(negedge clk);

        // 3: START held high -> back-to-back reports, each one cycle after DONE
        data = 8'h3C; start = 1'b1;
        capture_report(1'b0, DIV_A, 8'h3C, 1, "3C#1");
        capture_report(1'b0, DIV_A, 8'h3C, 1, "3C#2");
        capture_report(1'b0, DIV_A, 8'h3C, 1, "3C#3");
        start = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0) cnt++;
        end
        check("3C stops after START low", cnt, 0);

        // 4: START and DATA changes while busy are ignored
        data = 8'h12; start = 1'b1;
        capture_report(1'b0, DIV_A, 8'h12, 2, "12");
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0) cnt++;
        end
        check("12 no queued report", cnt, 0);

        // 5: reset in the 2nd character's data bits (cycle 53 would be a 0 bit)
        data = 8'hC3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (51) @(negedge clk);
        check("pre-reset busy", busy, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("abort tx", tx, 1'b1);
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) cnt++;
        end
        check("abort stays idle", cnt, 0);
        data = 8'h7E; start = 1'b1;
        capture_report(1'b0, DIV_A, 8'h7E, 0, "7E");
        repeat (2) @(negedge clk);

        // 6: default parameters, 104 cycles per bit
        data_b = 8'h00; start_b = 1'b1;
        capture_report(1'b1, DIV_B, 8'h00, 0, "00 def");
        @(negedge clk);
        check("00 def done one cycle", done_b, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
